// File: rtl/pll_lock_ctrl.sv
`timescale 1ns/1ps
// Purpose: PLL reset/lock sequencer; filters pll_lock and releases downstream resets in order.
// Latency: 2-cycle lock synchronizer; every output is registered (1 cycle after the synced decision).
// Backpressure: none; free-running control block, soft_rst is a single-cycle request honoured in any state.
//
// Ports:
//   sys_clk    - free-running board clock (same source as PLL clkin1)
//   rst_n      - synchronous active-low reset
//   pll_lock   - PLL LOCK, asynchronous to sys_clk
//   soft_rst   - single-cycle request to re-run the lock sequence
//   pll_rst    - to PLL RST, active high
//   rstn_out   - downstream active-low resets, bit 0 released first
//   locked     - filtered lock, high in RELEASE and RUN
//   relock_cnt - saturating count of lock losses seen in RELEASE/RUN
//   fail       - high in FAIL
//   state      - current state code (debug)
//
// Build option: define PLL_LOCK_CTRL_RETRY_LIMIT_EN to stop in FAIL after MAX_RETRY
// consecutive timeouts; without it timeouts retry forever and fail stays 0.
module pll_lock_ctrl #(
    parameter int RST_CYC      = 16,
    parameter int LOCK_TIMEOUT = 100000,
    parameter int STABLE_CYC   = 1024,
    parameter int STAGE_GAP    = 64,
    parameter int NUM_RST      = 3,
    parameter int MAX_RETRY    = 4
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               pll_lock,
    input  logic               soft_rst,
    output logic               pll_rst,
    output logic [NUM_RST-1:0] rstn_out,
    output logic               locked,
    output logic [7:0]         relock_cnt,
    output logic               fail,
    output logic [2:0]         state
);

    localparam int RW = $clog2(RST_CYC) + 1;
    localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
    localparam int SW = $clog2(STABLE_CYC) + 1;
    localparam int GW = $clog2(STAGE_GAP) + 1;
    localparam int YW = $clog2(MAX_RETRY) + 1;

    localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(STAGE_GAP - 1);
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
    localparam logic [YW-1:0] RETRY_LAST = YW'(MAX_RETRY - 1);
`endif

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAIL      = 3'd5
    } state_t;

    logic               lk_meta;
    logic               lk;
    state_t             state_q,   state_nxt;
    logic [RW-1:0]      rst_cnt_q, rst_cnt_nxt;
    logic [TW-1:0]      to_cnt_q,  to_cnt_nxt;
    logic [SW-1:0]      stb_cnt_q, stb_cnt_nxt;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_nxt;
    logic [YW-1:0]      retry_q,   retry_nxt;
    logic [7:0]         relock_q,  relock_nxt;
    logic [NUM_RST-1:0] rstn_q,    rstn_nxt;
    logic               pll_rst_q, pll_rst_nxt;
    logic               locked_q,  locked_nxt;
    logic               fail_q,    fail_nxt;
    logic               timeout;
    logic               lock_loss;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            lk_meta   <= 1'b0;
            lk        <= 1'b0;
            state_q   <= S_RESET_PLL;
            rst_cnt_q <= '0;
            to_cnt_q  <= '0;
            stb_cnt_q <= '0;
            gap_cnt_q <= '0;
            retry_q   <= '0;
            relock_q  <= '0;
            rstn_q    <= '0;
            pll_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            lk_meta   <= pll_lock;
            lk        <= lk_meta;
            state_q   <= state_nxt;
            rst_cnt_q <= rst_cnt_nxt;
            to_cnt_q  <= to_cnt_nxt;
            stb_cnt_q <= stb_cnt_nxt;
            gap_cnt_q <= gap_cnt_nxt;
            retry_q   <= retry_nxt;
            relock_q  <= relock_nxt;
            rstn_q    <= rstn_nxt;
            pll_rst_q <= pll_rst_nxt;
            locked_q  <= locked_nxt;
            fail_q    <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        rst_cnt_nxt = rst_cnt_q;
        to_cnt_nxt  = to_cnt_q;
        stb_cnt_nxt = stb_cnt_q;
        gap_cnt_nxt = gap_cnt_q;
        retry_nxt   = retry_q;
        relock_nxt  = relock_q;
        rstn_nxt    = rstn_q;
        timeout     = 1'b0;
        lock_loss   = 1'b0;

        case (state_q)
            S_RESET_PLL: begin
                rstn_nxt = '0;
                if (rst_cnt_q == RST_LAST) begin
                    state_nxt  = S_WAIT_LOCK;
                    to_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = rst_cnt_q + RW'(1);
                end
            end
            // Timeout wins over any lock progress on the same cycle.
            S_WAIT_LOCK: begin
                if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt_q + TW'(1);
                    if (lk) begin
                        state_nxt   = S_STABLE;
                        stb_cnt_nxt = SW'(1);
                    end
                end
            end
            S_STABLE: begin
                if (to_cnt_q == TO_LAST) begin
                    timeout = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt_q + TW'(1);
                    if (!lk) begin
                        state_nxt = S_WAIT_LOCK;
                    end else if (stb_cnt_q == STB_LAST) begin
                        state_nxt   = S_RELEASE;
                        gap_cnt_nxt = '0;
                        rstn_nxt    = '0;
                    end else begin
                        stb_cnt_nxt = stb_cnt_q + SW'(1);
                    end
                end
            end
            // Released bits form a thermometer code growing from bit 0.
            S_RELEASE: begin
                if (!lk) begin
                    lock_loss = 1'b1;
                end else if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_nxt = '0;
                    rstn_nxt    = (rstn_q << 1) | NUM_RST'(1);
                    if (&rstn_nxt) begin
                        state_nxt = S_RUN;
                        retry_nxt = '0;
                    end
                end else begin
                    gap_cnt_nxt = gap_cnt_q + GW'(1);
                end
            end
            S_RUN: begin
                if (!lk) begin
                    lock_loss = 1'b1;
                end
            end
            S_FAIL: begin
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
                rstn_nxt = '0;
`else
                state_nxt   = S_RESET_PLL;
                rst_cnt_nxt = '0;
                rstn_nxt    = '0;
`endif
            end
            default: begin
                state_nxt   = S_RESET_PLL;
                rst_cnt_nxt = '0;
                rstn_nxt    = '0;
            end
        endcase

        if (timeout) begin
            retry_nxt = (retry_q == '1) ? retry_q : retry_q + YW'(1);
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
            if (retry_q == RETRY_LAST) begin
                state_nxt = S_FAIL;
            end else begin
                state_nxt   = S_RESET_PLL;
                rst_cnt_nxt = '0;
            end
`else
            state_nxt   = S_RESET_PLL;
            rst_cnt_nxt = '0;
`endif
        end

        if (lock_loss) begin
            relock_nxt  = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
            state_nxt   = S_RESET_PLL;
            rst_cnt_nxt = '0;
            rstn_nxt    = '0;
        end

        // Software request overrides lock loss and timeout decided this cycle.
        if (soft_rst) begin
            state_nxt   = S_RESET_PLL;
            rst_cnt_nxt = '0;
            rstn_nxt    = '0;
            relock_nxt  = relock_q;
            retry_nxt   = (state_q == S_FAIL) ? '0 : retry_q;
        end

        pll_rst_nxt = (state_nxt == S_RESET_PLL) || (state_nxt == S_FAIL);
        locked_nxt  = (state_nxt == S_RELEASE) || (state_nxt == S_RUN);
`ifdef PLL_LOCK_CTRL_RETRY_LIMIT_EN
        fail_nxt    = (state_nxt == S_FAIL);
`else
        fail_nxt    = 1'b0;
`endif
    end

    assign pll_rst    = pll_rst_q;
    assign rstn_out   = rstn_q;
    assign locked     = locked_q;
    assign relock_cnt = relock_q;
    assign fail       = fail_q;
    assign state      = state_q;

endmodule

// File: doc/pll_lock_ctrl.md
# pll_lock_ctrl

Reset and lock sequencer for the video PLL. It drives the PLL's RST input and filters the asynchronous `pll_lock` output. It releases a bank of downstream active-low resets in a fixed order only after the PLL has been stably locked. On lock loss, lock timeout or a software request, it re-runs the whole lock sequence. It runs on the free-running board clock that also feeds the PLL's `clkin1`.

## Interface
- `RST_CYC`, 16, cycles `pll_rst` is held high per attempt (≥2)
- `LOCK_TIMEOUT`, 100000, cycles allowed from `pll_rst` release to filtered lock
- `STABLE_CYC`, 1024, consecutive synced-lock-high cycles required
- `STAGE_GAP`, 64, cycles between successive `rstn_out` releases
- `NUM_RST`, 3, number of downstream reset outputs (1–8)
- `MAX_RETRY`, 4, consecutive timeouts before FAIL (only with the macro)
- `sys_clk  in  1  free-running board clock (same source as PLL clkin1)`
- `rst_n  in  1  reset; synchronous and active-low`
- `pll_lock  in  1  PLL LOCK, asynchronous to sys_clk`
- `soft_rst  in  1  single-cycle request to re-run the lock sequence`
- `pll_rst  out  1  to PLL RST, active high`
- `rstn_out  out  NUM_RST  downstream active-low resets; bit 0 is released first`
- `locked  out  1  filtered lock; high in RELEASE and RUN`
- `relock_cnt  out  8  saturating count of lock losses seen in RELEASE/RUN`
- `fail  out  1  high in FAIL`
- `state  out  3  current state code, for debug`

## Operation
- `pll_lock` passes through a 2-FF synchronizer. All decisions use the synced value `lk`.
- States and codes: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5.
- RESET_PLL:
  - `pll_rst`=1 and `rstn_out`=0.
  - After exactly RST_CYC cycles, go to WAIT_LOCK and clear the timeout counter.
- WAIT_LOCK:
  - `pll_rst`=0.
  - `lk`=1 → STABLE, with the stable counter set to 1.
- STABLE:
  - `lk`=1 increments the stable counter. When the count reaches STABLE_CYC → RELEASE.
  - `lk`=0 → WAIT_LOCK. The timeout counter keeps running.
- Timeout:
  - The timeout counter runs through WAIT_LOCK and STABLE.
  - When it reaches LOCK_TIMEOUT, go to RESET_PLL and increment `retry_cnt`.
- RELEASE:
  - `rstn_out[i]` rises (i+1)·STAGE_GAP cycles after RELEASE entry.
  - Released bits stay high.
  - After the last bit rises, go to RUN and clear `retry_cnt`.
- RUN: hold everything steady.
- Lock loss (`lk`=0 in RELEASE or RUN):
  - All `rstn_out` go to 0 on the next edge.
  - `relock_cnt` increments, saturating at 255.
  - Go to RESET_PLL.
- `soft_rst`:
  - In any state, go to RESET_PLL and restart RST_CYC. `rstn_out` goes to 0.
  - `relock_cnt` is unchanged.
  - In FAIL, `soft_rst` also clears `fail` and `retry_cnt`.
  - `soft_rst` has priority over lock loss and timeout in the same cycle.
- Reset values: `pll_rst`=1, `rstn_out`=0, `locked`=0, `relock_cnt`=0, `fail`=0, `state`=0, all counters 0.
  - The synchronizer flops also reset to 0.
  - Deasserting `rst_n` mid-sequence restarts from RESET_PLL.

## Timing
- All outputs are registered.
- The synchronizer adds 2 cycles from a `pll_lock` edge to `lk`.
- `pll_rst` is high for exactly RST_CYC cycles per attempt.
- `locked` rises on the same edge as entry into RELEASE.
- From `lk` loss to `rstn_out`=0 and `locked`=0: 1 cycle (3 cycles from the `pll_lock` pin).
- Counter widths are `$clog2` of the respective parameter plus 1. No wrap occurs in any count.

## Configuration
- `PLL_LOCK_CTRL_RETRY_LIMIT_EN` defined:
  - When a timeout occurs with `retry_cnt`=MAX_RETRY−1, go to FAIL.
  - In FAIL: `pll_rst`=1, `rstn_out`=0, `fail`=1, until `soft_rst` or `rst_n`.
- Not defined:
  - Timeouts retry indefinitely, `fail` is constant 0, and FAIL is unreachable.

## Test plan
All scenarios use RST_CYC=4, LOCK_TIMEOUT=50, STABLE_CYC=8, STAGE_GAP=4, NUM_RST=3, MAX_RETRY=2.

- **Nominal:** `pll_lock` rises 10 cycles after `pll_rst` falls.
  - `pll_rst` is high for 4 cycles.
  - `locked` rises 2+8 cycles after the `pll_lock` edge.
  - `rstn_out` bits rise 4, 8 and 12 cycles after `locked`; `state` reaches 4.
- **Glitch during STABLE:** `pll_lock` drops for 1 cycle after being high for 5 cycles.
  - `state` returns to 1, then 2.
  - `locked` rises 8 cycles after the final rising `lk`; `relock_cnt` stays 0.
- **Lock loss in RUN:** `pll_lock` goes low.
  - 3 cycles later `rstn_out`=0, `locked`=0, `relock_cnt`=1, `pll_rst`=1 for 4 cycles.
  - The sequence then repeats.
- **Timeout with the macro:** `pll_lock` is held 0.
  - Two 50-cycle timeouts, then `state`=5 and `fail`=1.
  - `soft_rst` clears `fail`, and `pll_rst` is held high for 4 cycles.
- **Timeout without the macro:** `pll_lock` is held 0 for 500 cycles.
  - `pll_rst` pulses every 54 cycles and `fail` stays 0.
- **Simultaneous events:** `soft_rst` and a `pll_lock` drop coincide in RUN.
  - The controller goes to RESET_PLL, `relock_cnt` is unchanged, and `rstn_out`=0 next cycle.
